// File: rtl/alu_issue_ctrl_if.sv
// Bundle of the decoder-side instruction handshake and the ALU-side
// operand/result bus for alu_issue_ctrl.
//
// Handshake: an instruction transfers on a rising edge where in_valid and
// in_ready are both high. in_ready is high only while the controller is idle
// and not in reset. The issuer must hold in_valid and the in_* fields stable
// until that transfer edge. in_valid seen while in_ready is low is ignored and
// nothing is buffered. done, err and out_valid are single-cycle pulses with no
// back-pressure.
interface alu_issue_ctrl_if #(
  parameter int N  = 8,
  parameter int RA = 3
);
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_op;
  logic [RA-1:0] in_rd;
  logic [RA-1:0] in_rs;
  logic [N-1:0]  in_imm;
  logic [N-1:0]  alu_a;
  logic [N-1:0]  alu_b;
  logic [1:0]    alu_func;
  logic [N-1:0]  alu_result;
  logic [N-1:0]  out_data;
  logic          out_valid;
  logic          done;
  logic          err;

  // Controller side: consumes instructions and drives the ALU.
  modport master (
    input  in_valid, in_op, in_rd, in_rs, in_imm, alu_result,
    output in_ready, alu_a, alu_b, alu_func, out_data, out_valid, done, err
  );

  // Environment side: instruction source plus the combinational ALU.
  modport slave (
    output in_valid, in_op, in_rd, in_rs, in_imm, alu_result,
    input  in_ready, alu_a, alu_b, alu_func, out_data, out_valid, done, err
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// picoMIPS ALU issue controller. Takes one decoded instruction per
// handshake, reads operands from a small register file, presents them to an
// external combinational ALU, captures the result and writes it back.
// Four-state sequence IDLE -> READ -> EXEC -> WB, so one instruction per
// four cycles. The current state is exposed on dbg_state.
module alu_issue_ctrl #(
  parameter int         N         = 8,
  parameter int         RA        = 3,
  parameter logic [1:0] FUNC_RB   = 2'b00,
  parameter logic [1:0] FUNC_ADD  = 2'b10,
  parameter logic [1:0] FUNC_MULT = 2'b11
) (
  input  logic                  clk,
  input  logic                  reset,
  alu_issue_ctrl_if.master      bus,
  output logic [1:0]            dbg_state
);

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_ADDI = 3'd2;
  localparam logic [2:0] OP_MUL  = 3'd3;
  localparam logic [2:0] OP_MULI = 3'd4;
  localparam logic [2:0] OP_LDI  = 3'd5;
  localparam logic [2:0] OP_OUT  = 3'd6;
  localparam logic [2:0] OP_ILL  = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_t;

  state_t        state_q, state_d;

  logic [2:0]    op_q;
  logic [RA-1:0] rd_q;
  logic [RA-1:0] rs_q;
  logic [N-1:0]  imm_q;
  logic [N-1:0]  result_q;
  logic [N-1:0]  alu_a_q;
  logic [N-1:0]  alu_b_q;
  logic [1:0]    alu_func_q;
  logic [N-1:0]  out_data_q;
  logic [N-1:0]  rf [2**RA];

  logic [N-1:0]  rd_val;
  logic [N-1:0]  rs_val;
  logic          wr_en;

  // r0 always reads as zero regardless of storage contents.
  assign rd_val = (rd_q == '0) ? '0 : rf[rd_q];
  assign rs_val = (rs_q == '0) ? '0 : rf[rs_q];

  // Only arithmetic and LDI write back; r0 writes are dropped.
  assign wr_en = (op_q != OP_NOP) && (op_q != OP_OUT) && (op_q != OP_ILL) &&
                 (rd_q != '0);

  assign bus.alu_a    = alu_a_q;
  assign bus.alu_b    = alu_b_q;
  assign bus.alu_func = alu_func_q;
  assign bus.out_data = out_data_q;
  assign dbg_state    = state_q;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and Moore outputs; pulses are masked while reset is high.
  always_comb begin
    state_d       = state_q;
    bus.in_ready  = 1'b0;
    bus.done      = 1'b0;
    bus.err       = 1'b0;
    bus.out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        bus.in_ready = !reset;
        if (bus.in_valid) state_d = READ;
      end
      READ: state_d = EXEC;
      EXEC: state_d = WB;
      WB: begin
        bus.done      = !reset;
        bus.err       = !reset && (op_q == OP_ILL);
        bus.out_valid = !reset && (op_q == OP_OUT);
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: latch instruction, drive ALU operands, capture result, write back.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q       <= OP_NOP;
      rd_q       <= '0;
      rs_q       <= '0;
      imm_q      <= '0;
      result_q   <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_func_q <= FUNC_RB;
      out_data_q <= '0;
      for (int i = 0; i < 2**RA; i++) rf[i] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            op_q  <= bus.in_op;
            rd_q  <= bus.in_rd;
            rs_q  <= bus.in_rs;
            imm_q <= bus.in_imm;
          end
        end
        READ: begin
          alu_a_q <= rd_val;
          case (op_q)
            OP_ADD: begin
              alu_b_q    <= rs_val;
              alu_func_q <= FUNC_ADD;
            end
            OP_ADDI: begin
              alu_b_q    <= imm_q;
              alu_func_q <= FUNC_ADD;
            end
            OP_MUL: begin
              alu_b_q    <= rs_val;
              alu_func_q <= FUNC_MULT;
            end
            OP_MULI: begin
              alu_b_q    <= imm_q;
              alu_func_q <= FUNC_MULT;
            end
            OP_LDI: begin
              alu_b_q    <= imm_q;
              alu_func_q <= FUNC_RB;
            end
            OP_OUT: begin
              alu_b_q    <= rd_val;
              alu_func_q <= FUNC_RB;
            end
            default: begin
              alu_b_q    <= '0;
              alu_func_q <= FUNC_RB;
            end
          endcase
        end
        EXEC: begin
          result_q <= bus.alu_result;
          // Load out_data here so it is already valid during the out_valid pulse.
          if (op_q == OP_OUT) out_data_q <= rd_val;
        end
        WB: begin
          if (wr_en) rf[rd_q] <= result_q;
        end
        default: ;
      endcase
    end
  end

endmodule
